pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque packed payload of DATA_W bits between two pipeline stages.
- Uses a valid/ready handshake, a 2-entry skid buffer and a synchronous flush (bubble insertion).
- Gives full throughput under backpressure, with no combinational path from i_ready to o_ready.

Parameters:
- DATA_W, 160, payload width in bits (packed stage fields; e.g. ID/EX = pc, rs_1, rs_2, rd_num, immediates, opcode, func fields).
- CLEAR_PAYLOAD, 1, 1 = payload registers zeroed on flush; 0 = payload held on flush, only valid state cleared.
- DBG_W, 64, debug sideband width (pc + inst); used only when PIPE_STAGE_DEBUG_EN is defined.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  synchronous flush; stage becomes empty next cycle.
- i_valid  in  1  upstream payload valid.
- o_ready  out  1  stage can accept; registered, derived from state only.
- i_data  in  DATA_W  upstream payload.
- o_valid  out  1  downstream payload valid.
- i_ready  in  1  downstream accepts.
- o_data  out  DATA_W  payload to downstream stage, driven from the main register.
- i_dbg  in  DBG_W  debug sideband in (PIPE_STAGE_DEBUG_EN only).
- o_dbg  out  DBG_W  debug sideband out (PIPE_STAGE_DEBUG_EN only).

Behaviour:
- Handshake events:
  - in_fire = i_valid & o_ready.
  - out_fire = o_valid & i_ready.
- Storage: main register (drives o_data) and skid register.
- States: EMPTY, FULL, SKID. Outputs derived from state:
  - o_valid = (state != EMPTY).
  - o_ready = (state != SKID).
- Reset (async, i_rst=1), effective immediately:
  - state = EMPTY, o_valid = 0, o_ready = 1.
  - Main and skid payload = 0; o_data = 0.
  - All payload bits are cleared, not a subset.
- Transitions, evaluated at the clock edge when i_flush = 0:
  - EMPTY: in_fire -> FULL, main <= i_data; otherwise stay.
  - FULL, in_fire & out_fire -> FULL, main <= i_data.
  - FULL, in_fire & !out_fire -> SKID, skid <= i_data; main holds.
  - FULL, !in_fire & out_fire -> EMPTY.
  - FULL, neither event -> hold.
  - SKID: out_fire -> FULL, main <= skid. in_fire is impossible (o_ready = 0). Otherwise hold.
- Flush (i_flush = 1) has the highest priority after reset:
  - Next state = EMPTY regardless of in_fire or out_fire.
  - Any same-cycle in_fire payload is dropped; the upstream sees it as accepted.
  - A same-cycle out_fire completes normally on the downstream side.
  - CLEAR_PAYLOAD = 1: main and skid zeroed. CLEAR_PAYLOAD = 0: contents held, marked invalid.
- Latency and throughput:
  - 1 cycle: data accepted at edge N is on o_data with o_valid after edge N.
  - 1 transfer/cycle while i_ready = 1.
  - Payload order is strictly FIFO; no data is lost on backpressure.
- Stall: i_ready = 0 holds o_data and o_valid stable. Once in SKID, o_ready deasserts the cycle after the overflow accept.
- No X propagation: the payload registers load only on the transitions above.

Optional Feature:
- Macro: PIPE_STAGE_DEBUG_EN.
- Defined:
  - i_dbg and o_dbg exist and travel in lockstep with the payload through main and skid.
  - Sideband is zeroed on reset, and zeroed on flush regardless of CLEAR_PAYLOAD.
- Undefined:
  - Ports and registers are absent.
  - Payload behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - State encoding constants: EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2.
  - Default DATA_W per stage boundary: IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W.
  - DBG_W default.
- Sub-module pipe_slot:
  - Single register with load, clear and async reset; width-parametrised.
  - Instantiated twice (main, skid), each carrying payload plus the optional debug sideband.

Test Plan:
- Reset: assert i_rst mid-stream while in SKID -> immediately o_valid = 0, o_ready = 1, o_data = 0. After release, first accept of 0xA5 appears one cycle later.
- Streaming: i_ready = 1, send 0x1, 0x2, 0x3 on consecutive cycles -> same values on o_data with o_valid high on consecutive cycles, 1-cycle latency, no bubbles.
- Backpressure: send 0x10, 0x11 with i_ready = 0 -> state SKID, o_ready = 0, o_data = 0x10. Raise i_ready -> outputs 0x10 then 0x11, o_ready returns to 1.
- Flush: in SKID with i_valid = 1, pulse i_flush -> next cycle o_valid = 0, state EMPTY, o_data = 0 (CLEAR_PAYLOAD = 1); flushed data never appears.
- Flush collision: i_flush and in_fire of 0x77 on the same edge -> 0x77 dropped, o_valid = 0. Next accept of 0x78 is output normally.
- Debug (PIPE_STAGE_DEBUG_EN): i_dbg = {pc 0x100, inst 0x00500093} with payload 0x5 -> o_dbg matches in the same cycle as o_data = 0x5, including through the SKID path.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the parametrised inter-stage pipeline register.
// The debug sideband width is only consumed when PIPE_STAGE_DEBUG_EN is defined.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // Packed field widths of the classic stage boundaries
    localparam int IF_ID_W   = 64;
    localparam int ID_EX_W   = 160;
    localparam int EX_MEM_W  = 105;
    localparam int MEM_WB_W  = 71;

    localparam int DBG_W_DEF = 64;

endpackage

// File: rtl/pipe_slot.sv
// Width-parametrised storage register with load, per-bit synchronous clear and async reset.
// A load takes precedence over the clear mask; the caller never asserts both together.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_clr_mask,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q & ~i_clr_mask;
        if (i_load) begin
            q_d = i_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional debug sideband travelling with the payload: define PIPE_STAGE_DEBUG_EN.
//   state | meaning
//   EMPTY | no payload held, o_valid = 0
//   FULL  | main holds the output word
//   SKID  | main and skid both hold words, o_ready = 0
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W        = ID_EX_W,
    parameter bit CLEAR_PAYLOAD = 1'b1
`ifdef PIPE_STAGE_DEBUG_EN
    ,
    parameter int DBG_W         = DBG_W_DEF
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
`ifdef PIPE_STAGE_DEBUG_EN
    ,
    input  logic [DBG_W-1:0]  i_dbg,
    output logic [DBG_W-1:0]  o_dbg
`endif
);

`ifdef PIPE_STAGE_DEBUG_EN
    localparam int SLOT_W = DATA_W + DBG_W;
    // Sideband is always wiped on flush; payload only when CLEAR_PAYLOAD is set
    localparam logic [SLOT_W-1:0] FLUSH_MASK = {{DBG_W{1'b1}}, {DATA_W{CLEAR_PAYLOAD}}};
`else
    localparam int SLOT_W = DATA_W;
    localparam logic [SLOT_W-1:0] FLUSH_MASK = {DATA_W{CLEAR_PAYLOAD}};
`endif

    pipe_state_e state_q;
    pipe_state_e state_d;

    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              skid_load;
    logic              main_from_skid;
    logic [SLOT_W-1:0] in_word;
    logic [SLOT_W-1:0] main_in;
    logic [SLOT_W-1:0] main_q;
    logic [SLOT_W-1:0] skid_q;
    logic [SLOT_W-1:0] clr_mask;

`ifdef PIPE_STAGE_DEBUG_EN
    assign in_word = {i_dbg, i_data};
`else
    assign in_word = i_data;
`endif

    assign o_valid  = (state_q != EMPTY);
    assign o_ready  = (state_q != SKID);
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = FULL;
                        main_load = 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = SKID;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_d        = FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign clr_mask = i_flush ? FLUSH_MASK : '0;
    assign main_in  = main_from_skid ? skid_q : in_word;

    pipe_slot #(.W(SLOT_W)) u_main (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (main_load),
        .i_clr_mask (clr_mask),
        .i_d        (main_in),
        .o_q        (main_q)
    );

    pipe_slot #(.W(SLOT_W)) u_skid (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (skid_load),
        .i_clr_mask (clr_mask),
        .i_d        (in_word),
        .o_q        (skid_q)
    );

    assign o_data = main_q[DATA_W-1:0];
`ifdef PIPE_STAGE_DEBUG_EN
    assign o_dbg  = main_q[SLOT_W-1:DATA_W];
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table plus hand-written reset sequence.
// Also checks the debug sideband when built with PIPE_STAGE_DEBUG_EN.
module tb_pipe_stage_reg;

    localparam int DW = 160;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
`ifdef PIPE_STAGE_DEBUG_EN
    logic [63:0]   i_dbg = '0;
    logic [63:0]   o_dbg;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    pipe_stage_reg #(.DATA_W(DW), .CLEAR_PAYLOAD(1'b1)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
`ifdef PIPE_STAGE_DEBUG_EN
        ,
        .i_dbg   (i_dbg),
        .o_dbg   (o_dbg)
`endif
    );

    typedef struct {
        logic          flush;
        logic          valid;
        logic          ready;
        logic [DW-1:0] data;
        logic          exp_valid;
        logic          exp_ready;
        logic [DW-1:0] exp_data;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

`ifdef PIPE_STAGE_DEBUG_EN
    // pc 0x100 offset by the low payload word, inst 0x00500093
    function automatic logic [63:0] dbg_of(input logic [DW-1:0] d);
        if (d == '0) return 64'h0;
        return {32'h100 + d[31:0], 32'h0050_0093};
    endfunction
`endif

    task automatic drive(input logic f, input logic v, input logic r, input logic [DW-1:0] d);
        i_flush = f;
        i_valid = v;
        i_ready = r;
        i_data  = d;
`ifdef PIPE_STAGE_DEBUG_EN
        i_dbg   = dbg_of(d);
`endif
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic er, input logic [DW-1:0] ed);
        check({tag, ".o_valid"}, {{(DW-1){1'b0}}, o_valid}, {{(DW-1){1'b0}}, ev});
        check({tag, ".o_ready"}, {{(DW-1){1'b0}}, o_ready}, {{(DW-1){1'b0}}, er});
        check({tag, ".o_data"},  o_data, ed);
`ifdef PIPE_STAGE_DEBUG_EN
        check({tag, ".o_dbg"}, {{(DW-64){1'b0}}, o_dbg}, {{(DW-64){1'b0}}, dbg_of(ed)});
`endif
    endtask

    initial begin
        logic [DW-1:0] wide;
        wide = {5{32'hA5C3_0F1E}};

        //           flush valid ready data        ev   er   ed
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 160'h1,  1'b1, 1'b1, 160'h1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 160'h2,  1'b1, 1'b1, 160'h2};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 160'h3,  1'b1, 1'b1, 160'h3};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 160'h0,  1'b0, 1'b1, 160'h3};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 160'h10, 1'b1, 1'b1, 160'h10};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 160'h11, 1'b1, 1'b0, 160'h10};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 160'h12, 1'b1, 1'b0, 160'h10};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 160'h0,  1'b1, 1'b1, 160'h11};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 160'h0,  1'b0, 1'b1, 160'h11};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 160'h20, 1'b1, 1'b1, 160'h20};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 160'h21, 1'b1, 1'b0, 160'h20};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 160'h22, 1'b0, 1'b1, 160'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 160'h0,  1'b0, 1'b1, 160'h0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 160'h77, 1'b0, 1'b1, 160'h0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 160'h78, 1'b1, 1'b1, 160'h78};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 160'h0,  1'b0, 1'b1, 160'h0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, wide,    1'b1, 1'b1, wide};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 160'h30, 1'b1, 1'b0, wide};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 160'h31, 1'b1, 1'b1, 160'h30};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 160'h31, 1'b1, 1'b1, 160'h31};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 160'h0,  1'b0, 1'b1, 160'h31};

        #2 i_rst = 1'b1;
        #1 check_outputs("reset", 1'b0, 1'b1, '0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].flush, vecs[i].valid, vecs[i].ready, vecs[i].data);
            @(posedge i_clk);
            #1 check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ready, vecs[i].exp_data);
        end

        // Async reset while holding two words in the skid buffer
        drive(1'b0, 1'b1, 1'b0, 160'h40);
        @(posedge i_clk);
        #1 drive(1'b0, 1'b1, 1'b0, 160'h41);
        @(posedge i_clk);
        #1 check_outputs("pre_rst_skid", 1'b1, 1'b0, 160'h40);
        #2 i_rst = 1'b1;
        #1 check_outputs("rst_mid_skid", 1'b0, 1'b1, '0);
        #1 i_rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 160'hA5);
        #1 check_outputs("post_rst_idle", 1'b0, 1'b1, '0);
        @(posedge i_clk);
        #1 check_outputs("post_rst_a5", 1'b1, 1'b1, 160'hA5);
        drive(1'b0, 1'b0, 1'b1, 160'h0);
        @(posedge i_clk);
        #1 check_outputs("post_rst_drain", 1'b0, 1'b1, 160'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
